// File: rtl/spi_rd_capture_pkg.sv
// Shared types and constants for the SPI read-data capture block.
// Holds the FSM state encoding and the default frame geometry.
package spi_rd_pkg;

    localparam int ADDR_W          = 13;
    localparam int DEF_INSTR_BITS  = 16;
    localparam int DEF_DATA_BITS   = 8;
    localparam int DEF_TIMEOUT_CYC = 64;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        INSTR   = 2'd1,
        DATA    = 2'd2,
        WAIT_CS = 2'd3
    } rd_state_t;

    // The bit counter has to hold the larger phase length plus one.
    function automatic int cnt_width(input int a, input int b);
        return $clog2(((a > b) ? a : b) + 1);
    endfunction

endpackage

// File: rtl/spi_rd_capture_if.sv
// Bundle of the snooped SPI bus, the read request and the readback handshake.
// The master side is the generator/consumer, the slave side is spi_rd_capture.
interface spi_rd_capture_if #(
    parameter int DATA_BITS = spi_rd_pkg::DEF_DATA_BITS
);
    logic                          rd_en;
    logic [spi_rd_pkg::ADDR_W-1:0] addr;
    logic                          csb;
    logic                          sclk;
    logic                          sdio_i;
    logic [DATA_BITS-1:0]          rd_data;
    logic [spi_rd_pkg::ADDR_W-1:0] rd_addr;
    logic                          rd_valid;
    logic                          rd_ready;
    logic                          overrun;
    logic                          frame_err;
    logic                          timeout;

    modport master (
        output rd_en, addr, csb, sclk, sdio_i, rd_ready,
        input  rd_data, rd_addr, rd_valid, overrun, frame_err, timeout
    );

    modport slave (
        input  rd_en, addr, csb, sclk, sdio_i, rd_ready,
        output rd_data, rd_addr, rd_valid, overrun, frame_err, timeout
    );

endinterface

// File: rtl/spi_rd_capture_edge_det.sv
// Edge detector for the snooped csb/sclk lines of the 3-wire SPI bus.
// csb_d resets high so a bus that is idle at reset release produces no edge.
module spi_edge_det (
    input  logic clk,
    input  logic rst_n,
    input  logic csb,
    input  logic sclk,
    output logic fall_cs,
    output logic rise_cs,
    output logic rise_sck
);

    logic csb_d;
    logic sclk_d;

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            csb_d  <= 1'b1;
            sclk_d <= 1'b0;
        end else begin
            csb_d  <= csb;
            sclk_d <= sclk;
        end
    end

    // sclk edges only count while the frame is selected.
    assign fall_cs  = ~csb & csb_d;
    assign rise_cs  = csb & ~csb_d;
    assign rise_sck = sclk & ~sclk_d & ~csb;

endmodule

// File: rtl/spi_rd_capture.sv
// Captures the ADC read-data byte following each SPI read instruction and hands
// {addr, data} over valid/ready. Optional watchdog: define SPI_RD_TIMEOUT_EN.
module spi_rd_capture
    import spi_rd_pkg::*;
#(
    parameter int INSTR_BITS  = DEF_INSTR_BITS,
    parameter int DATA_BITS   = DEF_DATA_BITS,
    parameter int TIMEOUT_CYC = DEF_TIMEOUT_CYC
) (
    input logic             clk,
    input logic             rst_n,
    spi_rd_capture_if.slave bus
);

    localparam int CNT_W = cnt_width(INSTR_BITS, DATA_BITS);

    rd_state_t            state;
    rd_state_t            state_nxt;
    logic [CNT_W-1:0]     bit_cnt;
    logic [CNT_W-1:0]     bit_cnt_nxt;
    logic [DATA_BITS-1:0] shift;
    logic [DATA_BITS-1:0] shift_nxt;
    logic [ADDR_W-1:0]    tag;
    logic [DATA_BITS-1:0] rd_data_q;
    logic [ADDR_W-1:0]    rd_addr_q;
    logic                 rd_valid_q;
    logic                 overrun_q;
    logic                 frame_err_q;
    logic                 timeout_q;
    logic                 complete;
    logic                 frame_err_nxt;
    logic                 timeout_nxt;
    logic                 wd_expired;
    logic                 fall_cs;
    logic                 rise_cs;
    logic                 rise_sck;

    spi_edge_det u_edge_det (
        .clk      (clk),
        .rst_n    (rst_n),
        .csb      (bus.csb),
        .sclk     (bus.sclk),
        .fall_cs  (fall_cs),
        .rise_cs  (rise_cs),
        .rise_sck (rise_sck)
    );

`ifdef SPI_RD_TIMEOUT_EN
    localparam int WD_W = $clog2(TIMEOUT_CYC + 1);

    logic [WD_W-1:0] wd;

    // Watchdog runs only while a frame is in flight; expiry forces IDLE.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wd <= '0;
        end else if (state == IDLE) begin
            wd <= '0;
        end else begin
            wd <= wd + 1'b1;
        end
    end

    assign wd_expired = (state != IDLE) && (wd == WD_W'(TIMEOUT_CYC - 1));
`else
    logic unused_timeout_cfg;

    assign unused_timeout_cfg = (TIMEOUT_CYC == 0);
    assign wd_expired         = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Frame sequencing: instruction bits are only counted, data bits are shifted in.
    always_comb begin
        state_nxt     = state;
        bit_cnt_nxt   = bit_cnt;
        shift_nxt     = shift;
        complete      = 1'b0;
        frame_err_nxt = 1'b0;
        timeout_nxt   = 1'b0;
        if (wd_expired) begin
            timeout_nxt = 1'b1;
            state_nxt   = IDLE;
            bit_cnt_nxt = '0;
        end else begin
            case (state)
                IDLE: begin
                    if (fall_cs) begin
                        state_nxt   = INSTR;
                        bit_cnt_nxt = '0;
                    end
                end
                INSTR: begin
                    if (rise_cs) begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = IDLE;
                    end else if (rise_sck) begin
                        if (bit_cnt == CNT_W'(INSTR_BITS - 1)) begin
                            state_nxt   = DATA;
                            bit_cnt_nxt = '0;
                        end else begin
                            bit_cnt_nxt = bit_cnt + 1'b1;
                        end
                    end
                end
                DATA: begin
                    if (rise_cs) begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = IDLE;
                    end else if (rise_sck) begin
                        shift_nxt   = {shift[DATA_BITS-2:0], bus.sdio_i};
                        bit_cnt_nxt = bit_cnt + 1'b1;
                        if (bit_cnt == CNT_W'(DATA_BITS - 1)) begin
                            state_nxt = WAIT_CS;
                        end
                    end
                end
                WAIT_CS: begin
                    if (rise_cs) begin
                        complete  = 1'b1;
                        state_nxt = IDLE;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                end
            endcase
        end
    end

    // Output holding register: a held result is never overwritten, a new one is dropped instead.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bit_cnt     <= '0;
            shift       <= '0;
            tag         <= '0;
            rd_data_q   <= '0;
            rd_addr_q   <= '0;
            rd_valid_q  <= 1'b0;
            overrun_q   <= 1'b0;
            frame_err_q <= 1'b0;
            timeout_q   <= 1'b0;
        end else begin
            bit_cnt     <= bit_cnt_nxt;
            shift       <= shift_nxt;
            frame_err_q <= frame_err_nxt;
            timeout_q   <= timeout_nxt;
            overrun_q   <= 1'b0;
            if (bus.rd_en) begin
                tag <= bus.addr;
            end
            if (complete) begin
                if (!rd_valid_q || bus.rd_ready) begin
                    rd_data_q  <= shift;
                    rd_addr_q  <= tag;
                    rd_valid_q <= 1'b1;
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (rd_valid_q && bus.rd_ready) begin
                rd_valid_q <= 1'b0;
            end
        end
    end

    assign bus.rd_data   = rd_data_q;
    assign bus.rd_addr   = rd_addr_q;
    assign bus.rd_valid  = rd_valid_q;
    assign bus.overrun   = overrun_q;
    assign bus.frame_err = frame_err_q;
    assign bus.timeout   = timeout_q;

endmodule
